// File: rtl/ivs_ahb_sram_bridge.sv
// Purpose : AHB-Lite slave that turns each accepted transfer into one single-port SRAM access, with byte enables and transfer/error counters.
// Latency : writes have zero wait states; reads insert RD_LAT wait states; errors take the two-cycle ERROR response.
// Backpress: hready_out is held low during read wait states and ERR1; a new address phase is accepted only while hready_out is high.
module ivs_ahb_sram_bridge #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int RD_LAT = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              hclk,
  input  logic              hrst_n,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [31:0]       haddr,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [3:0]        hprot,
  input  logic              hready_in,
  output logic              hready_out,
  output logic [1:0]        hresp,
  output logic [DATA_W-1:0] hrdata,
  output logic              mem_rd,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       xfer_cnt,
  output logic [7:0]        err_cnt
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR      = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_RD_DATA = 3'd3;
  localparam logic [2:0] ST_ERR1    = 3'd4;
  localparam logic [2:0] ST_ERR2    = 3'd5;

  // First byte address past the end of the SRAM.
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);
  localparam logic [1:0]  RD_LAST    = 2'(RD_LAT - 1);

  logic [2:0]    state_q,    state_d;
  logic [AW-1:0] addr_q,     addr_d;
  logic [1:0]    size_q,     size_d;
  logic [1:0]    alo_q,      alo_d;
  logic [1:0]    rd_cnt_q,   rd_cnt_d;
  logic [15:0]   xfer_cnt_q, xfer_cnt_d;
  logic [7:0]    err_cnt_q,  err_cnt_d;

  logic accept;
  logic addr_err;

  // Burst type and protection do not change how a beat is served.
  logic unused_ok;
  assign unused_ok = ^{hburst, hprot};

  // Bus-facing outputs are decoded from state; the SRAM is only driven in data phases.
  always_comb begin
    hready_out = !((state_q == ST_RD_WAIT) || (state_q == ST_ERR1));
    hresp      = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? 2'b01 : 2'b00;
    hrdata     = (state_q == ST_RD_DATA) ? mem_rdata : '0;
    mem_we     = (state_q == ST_WR);
    mem_rd     = (state_q == ST_RD_WAIT) && (rd_cnt_q == 2'd0);
    mem_addr   = (mem_we || mem_rd) ? addr_q : '0;
    mem_wdata  = mem_we ? hwdata : '0;
    mem_be     = 4'b0000;
    if (mem_we) begin
      case (size_q)
        2'd0:    mem_be = 4'b0001 << alo_q;
        2'd1:    mem_be = 4'b0011 << alo_q;
        default: mem_be = 4'b1111;
      endcase
    end
    xfer_cnt = xfer_cnt_q;
    err_cnt  = err_cnt_q;
  end

  // Address-phase qualification and legality check of the incoming transfer.
  always_comb begin
    accept   = hsel && htrans[1] && hready_in && hready_out;
    addr_err = (hsize > 3'b010)
            || ((hsize == 3'b001) && haddr[0])
            || ((hsize == 3'b010) && (haddr[1:0] != 2'b00))
            || (haddr >= ADDR_LIMIT);
  end

  // Next-state, captured address phase and counter updates.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    alo_d      = alo_q;
    rd_cnt_d   = rd_cnt_q;
    xfer_cnt_d = xfer_cnt_q;
    err_cnt_d  = err_cnt_q;

    // A data phase finishing with OKAY counts as a completed transfer.
    if ((state_q == ST_WR) || (state_q == ST_RD_DATA)) begin
      xfer_cnt_d = xfer_cnt_q + 16'd1;
    end
    if ((state_q == ST_ERR2) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end

    case (state_q)
      ST_IDLE, ST_WR, ST_RD_DATA, ST_ERR2: begin
        // hready_out is high in all of these, so a new transfer may start here.
        state_d = ST_IDLE;
        if (accept) begin
          addr_d   = haddr[AW+1:2];
          size_d   = hsize[1:0];
          alo_d    = haddr[1:0];
          rd_cnt_d = 2'd0;
          if (addr_err) begin
            state_d = ST_ERR1;
          end else if (hwrite) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        if (rd_cnt_q == RD_LAST) begin
          state_d = ST_RD_DATA;
        end else begin
          rd_cnt_d = rd_cnt_q + 2'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops any transfer in flight.
  always_ff @(posedge hclk) begin
    if (!hrst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      size_q     <= 2'd0;
      alo_q      <= 2'd0;
      rd_cnt_q   <= 2'd0;
      xfer_cnt_q <= 16'd0;
      err_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      alo_q      <= alo_d;
      rd_cnt_q   <= rd_cnt_d;
      xfer_cnt_q <= xfer_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_ivs_ahb_sram_bridge.sv
// Purpose : directed bench for ivs_ahb_sram_bridge with a behavioural SRAM (RD_LAT=1, DEPTH=64).
// Latency : inputs are driven at the falling edge and outputs sampled 1 ns later.
// Backpress: hready_in is held high; stalls come only from the bridge itself.
module tb_ivs_ahb_sram_bridge;

  localparam logic [1:0] NS   = 2'b10;
  localparam logic [1:0] IDLE = 2'b00;

  logic        hclk = 1'b0;
  logic        hrst_n;
  logic        hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hready_in;
  logic        hready_out;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic        mem_rd;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [15:0] xfer_cnt;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;
  int rd_strobes = 0;
  int we_strobes = 0;
  int both_strobes = 0;
  int wait_cycles = 0;
  int rd_s, we_s, both_s, wait_s;

  logic [31:0] mem [64];

  always #5 hclk = ~hclk;

  ivs_ahb_sram_bridge #(.DATA_W(32), .DEPTH(64), .RD_LAT(1)) dut (
    .hclk(hclk), .hrst_n(hrst_n), .hsel(hsel), .htrans(htrans), .hwrite(hwrite),
    .haddr(haddr), .hwdata(hwdata), .hsize(hsize), .hburst(hburst), .hprot(hprot),
    .hready_in(hready_in), .hready_out(hready_out), .hresp(hresp), .hrdata(hrdata),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .xfer_cnt(xfer_cnt), .err_cnt(err_cnt)
  );

  // Synchronous SRAM, one-cycle read latency; preloaded with a pattern while in reset.
  always @(posedge hclk) begin
    if (!hrst_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
      mem_rdata <= 32'h0;
    end else begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
      if (mem_rd) mem_rdata <= mem[mem_addr];
    end
  end

  // Per-cycle strobe and wait-state tally.
  always @(negedge hclk) begin
    #2;
    if (mem_rd) rd_strobes++;
    if (mem_we) we_strobes++;
    if (mem_rd && mem_we) both_strobes++;
    if (hrst_n && !hready_out) wait_cycles++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
    hsel   = sel;
    htrans = trans;
    hwrite = wr;
    haddr  = addr;
    hsize  = size;
    hwdata = wdata;
  endtask

  initial begin
    hrst_n    = 1'b0;
    hburst    = 3'b000;
    hprot     = 4'b0011;
    hready_in = 1'b1;
    drive(1'b0, IDLE, 1'b0, 32'h0, 3'd2, 32'h0);

    // Reset held three cycles
    repeat (3) @(negedge hclk);
    #1;
    chk("rst_hready", 32'(hready_out), 32'd1);
    chk("rst_hresp",  32'(hresp),      32'd0);
    chk("rst_hrdata", hrdata,          32'd0);
    chk("rst_mem_rd", 32'(mem_rd),     32'd0);
    chk("rst_mem_we", 32'(mem_we),     32'd0);
    chk("rst_mem_be", 32'(mem_be),     32'd0);
    chk("rst_mem_addr",  32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata,     32'd0);
    chk("rst_xfer",   32'(xfer_cnt),   32'd0);
    chk("rst_err",    32'(err_cnt),    32'd0);
    hrst_n = 1'b1;

    // Word write 0x10 then read it back
    @(negedge hclk); drive(1'b1, NS, 1'b1, 32'h10, 3'd2, 32'h0); #1;
    chk("t2_idle_rdy", 32'(hready_out), 32'd1);
    @(negedge hclk); drive(1'b1, NS, 1'b0, 32'h10, 3'd2, 32'hDEAD_BEEF); #1;
    chk("t2_we",    32'(mem_we),   32'd1);
    chk("t2_be",    32'(mem_be),   32'hF);
    chk("t2_addr",  32'(mem_addr), 32'd4);
    chk("t2_wdata", mem_wdata,     32'hDEAD_BEEF);
    chk("t2_no_rd", 32'(mem_rd),   32'd0);
    @(negedge hclk); drive(1'b0, IDLE, 1'b0, 32'h0, 3'd2, 32'h0); #1;
    chk("t2_wait_rdy",  32'(hready_out), 32'd0);
    chk("t2_rd",        32'(mem_rd),     32'd1);
    chk("t2_rd_addr",   32'(mem_addr),   32'd4);
    chk("t2_wait_data", hrdata,          32'd0);
    @(negedge hclk); #1;
    chk("t2_data_rdy", 32'(hready_out), 32'd1);
    chk("t2_rdata",    hrdata,          32'hDEAD_BEEF);
    chk("t2_rd_pulse", 32'(mem_rd),     32'd0);
    @(negedge hclk); #1;
    chk("t2_xfer",       32'(xfer_cnt), 32'd2);
    chk("t2_idle_rdata", hrdata,        32'd0);

    // Byte write 0x13, half write 0x22, read back word 0x10
    @(negedge hclk); drive(1'b1, NS, 1'b1, 32'h13, 3'd0, 32'h0); #1;
    @(negedge hclk); drive(1'b1, NS, 1'b1, 32'h22, 3'd1, 32'h5500_0000); #1;
    chk("t3_byte_we",   32'(mem_we),   32'd1);
    chk("t3_byte_be",   32'(mem_be),   32'b1000);
    chk("t3_byte_addr", 32'(mem_addr), 32'd4);
    @(negedge hclk); drive(1'b1, NS, 1'b0, 32'h10, 3'd2, 32'hAABB_0000); #1;
    chk("t3_half_be",    32'(mem_be),   32'b1100);
    chk("t3_half_addr",  32'(mem_addr), 32'd8);
    chk("t3_half_wdata", mem_wdata,     32'hAABB_0000);
    @(negedge hclk); drive(1'b0, IDLE, 1'b0, 32'h0, 3'd2, 32'h0); #1;
    @(negedge hclk); #1;
    chk("t3_merge_rdata", hrdata, 32'h55AD_BEEF);
    @(negedge hclk); #1;
    chk("t3_xfer", 32'(xfer_cnt), 32'd5);

    // Misaligned word read, then out-of-range read
    rd_s = rd_strobes; we_s = we_strobes;
    @(negedge hclk); drive(1'b1, NS, 1'b0, 32'h102, 3'd2, 32'h0); #1;
    @(negedge hclk); drive(1'b0, IDLE, 1'b0, 32'h0, 3'd2, 32'h0); #1;
    chk("t4a_err1_rdy",  32'(hready_out), 32'd0);
    chk("t4a_err1_resp", 32'(hresp),      32'd1);
    @(negedge hclk); #1;
    chk("t4a_err2_rdy",  32'(hready_out), 32'd1);
    chk("t4a_err2_resp", 32'(hresp),      32'd1);
    @(negedge hclk); #1;
    chk("t4a_err_cnt", 32'(err_cnt), 32'd1);
    chk("t4a_resp_ok", 32'(hresp),   32'd0);
    @(negedge hclk); drive(1'b1, NS, 1'b0, 32'h100, 3'd2, 32'h0); #1;
    @(negedge hclk); drive(1'b0, IDLE, 1'b0, 32'h0, 3'd2, 32'h0); #1;
    chk("t4b_err1_rdy",  32'(hready_out), 32'd0);
    chk("t4b_err1_resp", 32'(hresp),      32'd1);
    @(negedge hclk); #1;
    chk("t4b_err2_rdy",  32'(hready_out), 32'd1);
    chk("t4b_err2_resp", 32'(hresp),      32'd1);
    @(negedge hclk); #1;
    chk("t4b_err_cnt",    32'(err_cnt),          32'd2);
    chk("t4_no_rd",       32'(rd_strobes - rd_s), 32'd0);
    chk("t4_no_we",       32'(we_strobes - we_s), 32'd0);
    chk("t4_xfer_steady", 32'(xfer_cnt),          32'd5);

    // Back-to-back write 0 / read 4 / write 8
    @(negedge hclk); drive(1'b1, NS, 1'b1, 32'h0, 3'd2, 32'h0); #1;
    rd_s = rd_strobes; we_s = we_strobes; both_s = both_strobes; wait_s = wait_cycles;
    @(negedge hclk); drive(1'b1, NS, 1'b0, 32'h4, 3'd2, 32'h1111_1111); #1;
    chk("t5_w0_we",   32'(mem_we),   32'd1);
    chk("t5_w0_addr", 32'(mem_addr), 32'd0);
    @(negedge hclk); drive(1'b1, NS, 1'b1, 32'h8, 3'd2, 32'h0); #1;
    chk("t5_r_rd",   32'(mem_rd),     32'd1);
    chk("t5_r_addr", 32'(mem_addr),   32'd1);
    chk("t5_r_rdy",  32'(hready_out), 32'd0);
    @(negedge hclk); #1;
    chk("t5_r_data", hrdata,          32'hA5A5_0001);
    chk("t5_r_rdy2", 32'(hready_out), 32'd1);
    @(negedge hclk); drive(1'b0, IDLE, 1'b0, 32'h0, 3'd2, 32'h2222_2222); #1;
    chk("t5_w8_we",    32'(mem_we),   32'd1);
    chk("t5_w8_addr",  32'(mem_addr), 32'd2);
    chk("t5_w8_wdata", mem_wdata,     32'h2222_2222);
    @(negedge hclk); #1;
    chk("t5_we_count",   32'(we_strobes - we_s),     32'd2);
    chk("t5_rd_count",   32'(rd_strobes - rd_s),     32'd1);
    chk("t5_both_count", 32'(both_strobes - both_s), 32'd0);
    chk("t5_wait_count", 32'(wait_cycles - wait_s),  32'd1);
    chk("t5_xfer",       32'(xfer_cnt),              32'd8);

    // Reset during a read wait state
    @(negedge hclk); drive(1'b1, NS, 1'b0, 32'h0, 3'd2, 32'h0); #1;
    @(negedge hclk); drive(1'b0, IDLE, 1'b0, 32'h0, 3'd2, 32'h0); hrst_n = 1'b0; #1;
    chk("t6_in_wait", 32'(hready_out), 32'd0);
    @(negedge hclk); #1;
    chk("t6_rdy",    32'(hready_out), 32'd1);
    chk("t6_rdata",  hrdata,          32'd0);
    chk("t6_no_rd",  32'(mem_rd),     32'd0);
    chk("t6_xfer",   32'(xfer_cnt),   32'd0);
    chk("t6_err",    32'(err_cnt),    32'd0);
    hrst_n = 1'b1;
    @(negedge hclk); #1;
    chk("t6_no_data_rdy", 32'(hready_out), 32'd1);
    chk("t6_no_data",     hrdata,          32'd0);
    chk("t6_resp",        32'(hresp),      32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
